// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter for one shared resource: req/gnt hold handshake,
// per-grant hold timeout with re-request masking, and a one-cycle bus turnaround.
module rr_req_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    busy,
  output logic                    timeout
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] mask;
  logic [HW-1:0]   hold_cnt;
  logic [NREQ-1:0] elig;
  logic [IW-1:0]   win;

  // First eligible index found when searching from p upward with wrap.
  function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] e, input logic [IW-1:0] p);
    logic [IW-1:0] w;
    logic          found;
    int            idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(p) + k) % NREQ;
      if (!found && e[idx[IW-1:0]]) begin
        w     = idx[IW-1:0];
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(NREQ - 1)) ? '0 : i + IW'(1);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign elig = req & ~mask;
  assign win  = pick(elig, ptr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= '0;
      mask     <= '0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      // A requester seen low is forgiven; a revoke below re-sets its own bit.
      mask    <= mask & req;
      case (state)
        IDLE: begin
          if (|elig) begin
            gnt      <= onehot(win);
            gnt_id   <= win;
            busy     <= 1'b1;
            hold_cnt <= HW'(1);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (!req[gnt_id]) begin
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= next_idx(gnt_id);
            state <= GAP;
          end else if (hold_cnt == HW'(MAX_HOLD)) begin
            gnt     <= '0;
            busy    <= 1'b0;
            timeout <= 1'b1;
            mask    <= (mask & req) | onehot(gnt_id);
            ptr     <= next_idx(gnt_id);
            state   <= GAP;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Randomized and directed bench for rr_req_arbiter against a cycle-level
// behavioural model of the grant/hold/timeout rules.
module tb_rr_req_arbiter;
  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 8;
  localparam int IW       = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_id;
  logic            busy;
  logic            timeout;
  logic [7:0]      act;

  int checks = 0;
  int errors = 0;

  // Model: current owner (-1 = none), cycles the owner has seen gnt,
  // pending turnaround, search start, blocked requesters, last owner.
  int         m_owner, m_held, m_ptr, m_last;
  bit         m_gap, m_to;
  bit [3:0]   m_blk;

  rr_req_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_id(gnt_id),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;
  assign act = {gnt, gnt_id, busy, timeout};

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_ptr = 0; m_last = 0;
    m_gap = 0; m_to = 0; m_blk = '0;
  endtask

  task automatic model_step(input logic [3:0] r);
    bit [3:0] nb;
    nb   = m_blk & r;
    m_to = 0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_gap = 1;
      end else if (m_held == MAX_HOLD) begin
        m_to = 1; nb[m_owner] = 1'b1;
        m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_gap = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (m_owner < 0 && r[i] && !m_blk[i]) begin
          m_owner = i; m_last = i; m_held = 1;
        end
      end
    end
    m_blk = nb;
  endtask

  function automatic logic [7:0] exp_vec();
    logic [3:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return {g, IW'(m_last), (m_owner >= 0), m_to};
  endfunction

  task automatic tick(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (act !== 8'h00) begin
      errors++; $display("FAIL reset_hold act=%h required=00", act);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(4'b0000);
      checks++;
      if (act !== 8'h00 || exp_vec() !== 8'h00) begin
        errors++; $display("FAIL reset_idle cyc=%0d act=%h required=00", c, act);
      end
    end
  endtask

  task automatic test_rotation();
    int       order[$];
    int       exp_order[5] = '{0, 1, 2, 3, 0};
    int       zero_run;
    bit       seen;
    logic [3:0] r, prev;
    do_reset();
    zero_run = 0; seen = 0; prev = '0;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_held >= 2) r[m_owner] = 1'b0;
      tick(r);
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL rotation_model cyc=%0d act=%h required=%h", c, act, exp_vec());
      end
      if (gnt != 0 && prev == 0) begin
        order.push_back(int'(gnt_id));
        if (seen) begin
          checks++;
          if (zero_run !== 2) begin
            errors++; $display("FAIL rotation_gap idle=%0d required=2", zero_run);
          end
        end
        seen = 1; zero_run = 0;
      end
      if (gnt == 0) zero_run++;
      prev = gnt;
    end
    checks++;
    if (order.size() != 5) begin
      errors++; $display("FAIL rotation_count grants=%0d required=5", order.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (order[k] !== exp_order[k]) begin
          errors++; $display("FAIL rotation_order idx=%0d got=%0d required=%0d", k, order[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int ngnt, npulse;
    do_reset();
    ngnt = 0; npulse = 0;
    for (int c = 0; c < 20; c++) begin
      tick(4'b0100);
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL timeout_model cyc=%0d act=%h required=%h", c, act, exp_vec());
      end
      if (gnt == 4'b0100) ngnt++;
      if (timeout) begin
        npulse++;
        checks++;
        if (gnt !== 4'b0000) begin
          errors++; $display("FAIL timeout_with_gnt gnt=%b required=0000", gnt);
        end
      end
    end
    checks++;
    if (ngnt !== MAX_HOLD) begin
      errors++; $display("FAIL timeout_hold cycles=%0d required=%0d", ngnt, MAX_HOLD);
    end
    checks++;
    if (npulse !== 1) begin
      errors++; $display("FAIL timeout_pulses got=%0d required=1", npulse);
    end
    tick(4'b0000);
    tick(4'b0100);
    checks++;
    if (gnt !== 4'b0100 || act !== exp_vec()) begin
      errors++; $display("FAIL timeout_regrant gnt=%b required=0100", gnt);
    end
  endtask

  task automatic test_no_preempt();
    bit got;
    do_reset();
    tick(4'b0010);
    tick(4'b0010);
    tick(4'b0010);
    for (int c = 0; c < 2; c++) begin
      tick(4'b1011);
      checks++;
      if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
        errors++; $display("FAIL no_preempt gnt=%b required=0010", gnt);
      end
    end
    got = 0;
    for (int c = 0; c < 4 && !got; c++) begin
      tick(4'b1001);
      if (gnt != 0) got = 1;
    end
    checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3 || act !== exp_vec()) begin
      errors++; $display("FAIL after_release gnt=%b id=%0d required=1000 id 3", gnt, gnt_id);
    end
  endtask

  task automatic test_release_at_max();
    do_reset();
    for (int c = 0; c < MAX_HOLD; c++) tick(4'b0010);
    checks++;
    if (gnt !== 4'b0010) begin
      errors++; $display("FAIL max_hold_owner gnt=%b required=0010", gnt);
    end
    tick(4'b0000);
    checks++;
    if (timeout !== 1'b0 || gnt !== 4'b0000 || act !== exp_vec()) begin
      errors++; $display("FAIL release_at_max timeout=%b gnt=%b required=0 0000", timeout, gnt);
    end
    tick(4'b0000);
    tick(4'b0010);
    checks++;
    if (gnt !== 4'b0010 || act !== exp_vec()) begin
      errors++; $display("FAIL release_no_mask gnt=%b required=0010", gnt);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    tick(4'b1000);
    tick(4'b1000);
    checks++;
    if (gnt !== 4'b1000) begin
      errors++; $display("FAIL midrst_setup gnt=%b required=1000", gnt);
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (act !== 8'h00) begin
      errors++; $display("FAIL midrst_async act=%h required=00", act);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tick(4'b1001);
    checks++;
    if (gnt !== 4'b0001 || act !== exp_vec()) begin
      errors++; $display("FAIL midrst_regrant gnt=%b required=0001", gnt);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    r = '0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      tick(r);
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL random_model cyc=%0d req=%b act=%h required=%h", c, r, act, exp_vec());
      end
      checks++;
      if ($countones(gnt) > 1 || busy !== (|gnt)) begin
        errors++; $display("FAIL random_invariant gnt=%b busy=%b", gnt, busy);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_timeout();
    test_no_preempt();
    test_release_at_max();
    test_reset_mid_grant();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
